// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // Width of the oversample edge counter for a given oversampling ratio.
    function automatic int edge_w(input int prescale);
        return $clog2(prescale);
    endfunction

    // Edge at which the sampler's majority vote is complete and checkers latch.
    function automatic int chk_edge(input int prescale);
        return prescale / 2 + 2;
    endfunction

    // Index of the stop bit: start + data bits + optional parity.
    function automatic logic [3:0] last_bit(input int data_width, input logic par_en_q);
        return 4'(data_width + (par_en_q ? 2 : 1));
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_counter.sv
// Oversample edge counter and bit counter for one UART frame.
// Latency: counts update one cycle after enable; clear takes effect next edge.
// Backpressure: none; free-running while enabled.
module edge_bit_counter #(
    parameter int PRESCALE = 8,
    parameter int EDGE_W   = $clog2(PRESCALE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [3:0]        bit_cnt,
    output logic              wrap
);

    localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(PRESCALE - 1);

    // Last oversample edge of the current bit.
    assign wrap = enable && (edge_cnt == EDGE_MAX);

    // Edge counter wraps every PRESCALE cycles and advances the bit index.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable) begin
            if (wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + EDGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detect, bit timing, checker/deserializer strobes.
// Latency: frame start seen at t, stop-bit end (data_valid) at t+PRESCALE*(bits)+... edge-exact.
// Backpressure: none; the serial line cannot be stalled, strobes are fire-and-forget.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic                        RX_IN,
    input  logic                        par_en,
    input  logic                        par_err,
    input  logic                        strt_glitch,
    input  logic                        stp_err,
    output logic                        dat_samp_en,
    output logic                        deser_en,
    output logic                        strt_chk_en,
    output logic                        par_chk_en,
    output logic                        stp_chk_en,
    output logic                        rst_check,
    output logic                        data_valid,
    output logic [$clog2(PRESCALE)-1:0] edge_cnt,
    output logic [3:0]                  bit_cnt
);

    localparam int                EDGE_W = edge_w(PRESCALE);
    localparam logic [EDGE_W-1:0] CHK    = EDGE_W'(chk_edge(PRESCALE));
    localparam logic [3:0]        DW     = 4'(DATA_WIDTH);

    state_t     state;
    logic       par_en_q;
    logic       active;
    logic       wrap;
    logic       at_chk;
    logic       stp_end;
    logic       frame_end;
    logic [3:0] last_idx;

    assign active    = state inside {START, DATA, PARITY, STOP};
    assign at_chk    = active && (edge_cnt == CHK);
    assign last_idx  = last_bit(DATA_WIDTH, par_en_q);
    assign stp_end   = (state == STOP) && wrap && (bit_cnt == last_idx);
    // Any exit back to IDLE/BREAK must leave the counters at zero for the next frame.
    assign frame_end = ((state == START) && wrap && strt_glitch) || stp_end;

    edge_bit_counter #(
        .PRESCALE (PRESCALE),
        .EDGE_W   (EDGE_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (RST),
        .enable   (active),
        .clear    (!active || frame_end),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .wrap     (wrap)
    );

    // Strobes decoded from registered state and counters only.
    assign dat_samp_en = active;
    assign strt_chk_en = (state == START)  && at_chk;
    assign deser_en    = (state == DATA)   && at_chk;
    assign par_chk_en  = (state == PARITY) && at_chk;
    assign stp_chk_en  = (state == STOP)   && at_chk;

    // Same-cycle responses to the line and checker results; suppressed during reset.
    assign rst_check  = !RST && (state == IDLE) && !RX_IN;
    assign data_valid = !RST && stp_end && !stp_err && !(par_en_q && par_err);

    // Frame sequencing; parity enable is frozen for the whole frame at start.
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= IDLE;
            par_en_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        par_en_q <= par_en;
                        state    <= START;
                    end
                end
                START: begin
                    if (wrap) state <= strt_glitch ? IDLE : DATA;
                end
                DATA: begin
                    if (wrap && (bit_cnt == DW)) state <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (wrap) state <= STOP;
                end
                STOP: begin
                    // A bad stop bit means the line may be held low (break): wait for idle.
                    if (stp_end) state <= stp_err ? BREAK : IDLE;
                end
                BREAK: begin
                    if (RX_IN) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RST, RX_IN, par_en, par_err, strt_glitch, stp_err;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, rst_check, data_valid;
    logic [2:0] edge_cnt;
    logic [3:0] bit_cnt;

    logic       rx16;
    logic       samp16, deser16, strt16, par16, stp16, rchk16, dv16;
    logic [3:0] edge16;
    logic [3:0] bit16;

    uart_rx_ctrl #(.PRESCALE(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .RST(RST), .RX_IN(RX_IN), .par_en(par_en), .par_err(par_err),
        .strt_glitch(strt_glitch), .stp_err(stp_err),
        .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .rst_check(rst_check),
        .data_valid(data_valid), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt)
    );

    uart_rx_ctrl #(.PRESCALE(16), .DATA_WIDTH(8)) dut16 (
        .clk(clk), .RST(RST), .RX_IN(rx16), .par_en(1'b0), .par_err(1'b0),
        .strt_glitch(1'b0), .stp_err(1'b0),
        .dat_samp_en(samp16), .deser_en(deser16), .strt_chk_en(strt16),
        .par_chk_en(par16), .stp_chk_en(stp16), .rst_check(rchk16),
        .data_valid(dv16), .edge_cnt(edge16), .bit_cnt(bit16)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npass = 0;
    int ntot  = 0;

    int q_rst[$], q_strt[$], q_deser[$], q_dbit[$], q_par[$], q_stp[$], q_dv[$], q_fall[$];
    int q16_strt[$], q16_sedge[$], q16_deser[$], q16_dedge[$], q16_dv[$];
    logic samp_prev = 1'b0;

    // Event log sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_check)   q_rst.push_back(cyc);
        if (strt_chk_en) q_strt.push_back(cyc);
        if (deser_en) begin
            q_deser.push_back(cyc);
            q_dbit.push_back(int'(bit_cnt));
        end
        if (par_chk_en)  q_par.push_back(cyc);
        if (stp_chk_en)  q_stp.push_back(cyc);
        if (data_valid)  q_dv.push_back(cyc);
        if (samp_prev && !dat_samp_en) q_fall.push_back(cyc);
        samp_prev = dat_samp_en;
        if (strt16) begin
            q16_strt.push_back(cyc);
            q16_sedge.push_back(int'(edge16));
        end
        if (deser16) begin
            q16_deser.push_back(cyc);
            q16_dedge.push_back(int'(edge16));
        end
        if (dv16) q16_dv.push_back(cyc);
    end

    task automatic clear_q();
        q_rst.delete(); q_strt.delete(); q_deser.delete(); q_dbit.delete();
        q_par.delete(); q_stp.delete(); q_dv.delete(); q_fall.delete();
        q16_strt.delete(); q16_sedge.delete(); q16_deser.delete(); q16_dedge.delete(); q16_dv.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits LSB first, optional parity, stop; t = cycle of the falling edge.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic pbit,
                              input logic stop_v, output int t);
        logic [15:0] bits;
        int nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
        if (par) begin
            bits[9] = pbit;
            nb      = 10;
        end
        bits[nb] = stop_v;
        nb       = nb + 1;
        t = cyc;
        for (int k = 0; k < nb; k++) begin
            RX_IN = bits[k];
            wait_cyc(8);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            RX_IN = (i == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            ntot++;
            if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, rst_check, data_valid} !== 7'b0)
                $display("FAIL reset_strobes: got %b expected 0000000",
                         {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, rst_check, data_valid});
            else npass++;
            ntot++;
            if (edge_cnt !== 3'd0) $display("FAIL reset_edge_cnt: got %0d expected 0", edge_cnt);
            else npass++;
            ntot++;
            if (bit_cnt !== 4'd0) $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt);
            else npass++;
            @(posedge clk);
            #1;
        end
        RST   = 1'b0;
        RX_IN = 1'b1;
        wait_cyc(3);
    endtask

    task automatic test_frame_a5();
        int t;
        int bad;
        clear_q();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, t);
        wait_cyc(4);
        ntot++;
        if (q_rst.size() !== 1 || q_rst[0] !== t) $display("FAIL a5_rst_check: got n=%0d at %0d expected 1 at %0d", q_rst.size(), q_rst[0], t);
        else npass++;
        ntot++;
        if (q_strt.size() !== 1 || q_strt[0] !== t + 7) $display("FAIL a5_strt_chk: got n=%0d at %0d expected 1 at %0d", q_strt.size(), q_strt[0], t + 7);
        else npass++;
        bad = 0;
        for (int i = 0; i < q_deser.size(); i++)
            if (q_deser[i] !== t + 15 + 8 * i || q_dbit[i] !== i + 1) bad++;
        ntot++;
        if (q_deser.size() !== 8 || bad !== 0) $display("FAIL a5_deser: got n=%0d misplaced=%0d expected 8 pulses at t+15+8i", q_deser.size(), bad);
        else npass++;
        ntot++;
        if (q_par.size() !== 0) $display("FAIL a5_par_chk: got %0d pulses expected 0", q_par.size());
        else npass++;
        ntot++;
        if (q_stp.size() !== 1 || q_stp[0] !== t + 79) $display("FAIL a5_stp_chk: got n=%0d at %0d expected 1 at %0d", q_stp.size(), q_stp[0], t + 79);
        else npass++;
        ntot++;
        if (q_dv.size() !== 1 || q_dv[0] !== t + 80) $display("FAIL a5_data_valid: got n=%0d at %0d expected 1 at %0d", q_dv.size(), q_dv[0], t + 80);
        else npass++;
        ntot++;
        if (q_fall.size() !== 1 || q_fall[0] !== t + 81) $display("FAIL a5_idle: got n=%0d at %0d expected 1 at %0d", q_fall.size(), q_fall[0], t + 81);
        else npass++;
    endtask

    task automatic test_parity();
        int t;
        par_en  = 1'b1;
        par_err = 1'b1;
        clear_q();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, t);
        wait_cyc(4);
        ntot++;
        if (q_par.size() !== 1 || q_par[0] !== t + 79) $display("FAIL perr_par_chk: got n=%0d at %0d expected 1 at %0d", q_par.size(), q_par[0], t + 79);
        else npass++;
        ntot++;
        if (q_stp.size() !== 1 || q_stp[0] !== t + 87) $display("FAIL perr_stp_chk: got n=%0d at %0d expected 1 at %0d", q_stp.size(), q_stp[0], t + 87);
        else npass++;
        ntot++;
        if (q_dv.size() !== 0) $display("FAIL perr_data_valid: got %0d pulses expected 0", q_dv.size());
        else npass++;
        ntot++;
        if (q_fall.size() !== 1 || q_fall[0] !== t + 89) $display("FAIL perr_idle: got n=%0d at %0d expected 1 at %0d", q_fall.size(), q_fall[0], t + 89);
        else npass++;
        // Clean parity; par_en dropped mid-frame must not shorten the frame.
        par_err = 1'b0;
        clear_q();
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b1, t);
            begin
                wait_cyc(30);
                par_en = 1'b0;
            end
        join
        wait_cyc(4);
        ntot++;
        if (q_par.size() !== 1 || q_par[0] !== t + 79) $display("FAIL pok_par_chk: got n=%0d at %0d expected 1 at %0d", q_par.size(), q_par[0], t + 79);
        else npass++;
        ntot++;
        if (q_dv.size() !== 1 || q_dv[0] !== t + 88) $display("FAIL pok_data_valid: got n=%0d at %0d expected 1 at %0d", q_dv.size(), q_dv[0], t + 88);
        else npass++;
    endtask

    task automatic test_glitch();
        int t;
        clear_q();
        strt_glitch = 1'b1;
        RX_IN = 1'b0;
        t = cyc;
        wait_cyc(3);
        RX_IN = 1'b1;
        wait_cyc(12);
        ntot++;
        if (q_strt.size() !== 1 || q_strt[0] !== t + 7) $display("FAIL glitch_strt_chk: got n=%0d at %0d expected 1 at %0d", q_strt.size(), q_strt[0], t + 7);
        else npass++;
        ntot++;
        if (q_fall.size() !== 1 || q_fall[0] !== t + 9) $display("FAIL glitch_idle: got n=%0d at %0d expected 1 at %0d", q_fall.size(), q_fall[0], t + 9);
        else npass++;
        ntot++;
        if (q_deser.size() !== 0 || q_dv.size() !== 0) $display("FAIL glitch_no_data: got deser=%0d dv=%0d expected 0 and 0", q_deser.size(), q_dv.size());
        else npass++;
        strt_glitch = 1'b0;
        clear_q();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, t);
        wait_cyc(4);
        ntot++;
        if (q_dv.size() !== 1 || q_dv[0] !== t + 80) $display("FAIL glitch_next_frame: got n=%0d at %0d expected 1 at %0d", q_dv.size(), q_dv[0], t + 80);
        else npass++;
    endtask

    task automatic test_break();
        int t;
        stp_err = 1'b1;
        clear_q();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, t);
        wait_cyc(20);
        ntot++;
        if (q_dv.size() !== 0) $display("FAIL break_data_valid: got %0d pulses expected 0", q_dv.size());
        else npass++;
        ntot++;
        if (q_rst.size() !== 1) $display("FAIL break_no_retrigger: got %0d rst_check expected 1", q_rst.size());
        else npass++;
        ntot++;
        if (q_fall.size() !== 1 || q_fall[0] !== t + 81) $display("FAIL break_enter: got n=%0d at %0d expected 1 at %0d", q_fall.size(), q_fall[0], t + 81);
        else npass++;
        RX_IN = 1'b1;
        wait_cyc(1);
        stp_err = 1'b0;
        clear_q();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, t);
        wait_cyc(4);
        ntot++;
        if (q_rst.size() !== 1 || q_rst[0] !== t) $display("FAIL break_exit_start: got n=%0d at %0d expected 1 at %0d", q_rst.size(), q_rst[0], t);
        else npass++;
        ntot++;
        if (q_dv.size() !== 1 || q_dv[0] !== t + 80) $display("FAIL break_exit_frame: got n=%0d at %0d expected 1 at %0d", q_dv.size(), q_dv[0], t + 80);
        else npass++;
    endtask

    task automatic test_midframe_reset();
        int t;
        clear_q();
        RX_IN = 1'b0;
        t = cyc;
        wait_cyc(1);
        RX_IN = 1'b1;
        wait_cyc(34);
        RST = 1'b1;
        @(negedge clk);
        ntot++;
        if (bit_cnt !== 4'd4 || edge_cnt !== 3'd2) $display("FAIL rst_mid_position: got bit %0d edge %0d expected bit 4 edge 2", bit_cnt, edge_cnt);
        else npass++;
        @(posedge clk);
        #1;
        RST = 1'b0;
        @(negedge clk);
        ntot++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== 3'd0 || bit_cnt !== 4'd0)
            $display("FAIL rst_mid_idle: got samp %0d edge %0d bit %0d expected 0 0 0", dat_samp_en, edge_cnt, bit_cnt);
        else npass++;
        wait_cyc(60);
        ntot++;
        if (q_dv.size() !== 0 || q_deser.size() !== 3) $display("FAIL rst_mid_aborted: got dv=%0d deser=%0d expected 0 and 3", q_dv.size(), q_deser.size());
        else npass++;
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        clear_q();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, t1);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, t2);
        wait_cyc(6);
        ntot++;
        if (q_rst.size() !== 2 || q_rst[1] !== t2 + 1) $display("FAIL b2b_second_start: got n=%0d at %0d expected 2 with second at %0d", q_rst.size(), q_rst[1], t2 + 1);
        else npass++;
        ntot++;
        if (q_dv.size() !== 2 || q_dv[0] !== t1 + 80 || q_dv[1] !== t1 + 161)
            $display("FAIL b2b_data_valid: got n=%0d at %0d,%0d expected 2 at %0d,%0d", q_dv.size(), q_dv[0], q_dv[1], t1 + 80, t1 + 161);
        else npass++;
    endtask

    task automatic test_prescale16();
        int t;
        int bad;
        clear_q();
        rx16 = 1'b0;
        t = cyc;
        wait_cyc(3);
        rx16 = 1'b1;
        wait_cyc(170);
        ntot++;
        if (q16_strt.size() !== 1 || q16_strt[0] !== t + 11 || q16_sedge[0] !== 10)
            $display("FAIL p16_strt_chk: got n=%0d at %0d edge %0d expected 1 at %0d edge 10", q16_strt.size(), q16_strt[0], q16_sedge[0], t + 11);
        else npass++;
        bad = 0;
        for (int i = 0; i < q16_deser.size(); i++)
            if (q16_deser[i] !== t + 27 + 16 * i || q16_dedge[i] !== 10) bad++;
        ntot++;
        if (q16_deser.size() !== 8 || bad !== 0) $display("FAIL p16_deser: got n=%0d misplaced=%0d expected 8 at t+27+16i edge 10", q16_deser.size(), bad);
        else npass++;
        ntot++;
        if (q16_dv.size() !== 1 || q16_dv[0] !== t + 160) $display("FAIL p16_data_valid: got n=%0d at %0d expected 1 at %0d", q16_dv.size(), q16_dv[0], t + 160);
        else npass++;
    endtask

    initial begin
        RST = 1'b1; RX_IN = 1'b1; rx16 = 1'b1;
        par_en = 1'b0; par_err = 1'b0; strt_glitch = 1'b0; stp_err = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_frame_a5();
        test_parity();
        test_glitch();
        test_break();
        test_midframe_reset();
        test_back_to_back();
        test_prescale16();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
